// File: rtl/booth_secuenciador.sv
// Operand sequencer for the 4-bit Booth multiplier: handshakes, watchdog, latency count.
// Optional self-check of the returned product enabled by defining BOOTH_CHECK_EN.
module booth_secuenciador #(
    parameter int N       = 4,
    parameter int TIMEOUT = 64,
    parameter int CW      = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_q,
    input  logic [N-1:0]    in_m,
    output logic [N-1:0]    mult_q,
    output logic [N-1:0]    mult_m,
    output logic            mult_start,
    input  logic            mult_fin,
    input  logic [2*N-1:0]  mult_resultado,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*N-1:0]  out_producto,
    output logic            out_error,
    output logic [CW-1:0]   out_ciclos,
    output logic            out_mismatch
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ARRANQUE = 2'd1;
    localparam logic [1:0] ESPERA   = 2'd2;
    localparam logic [1:0] SALIDA   = 2'd3;

    localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT);

    logic [1:0]    state;
    logic [CW-1:0] ciclos;
    logic          fin_bajo;
    logic          completo;
    logic          vencido;
    logic          mismatch_calc;

    // fin only counts once it has been seen low, so a stale high is ignored
    assign completo = mult_fin && fin_bajo;
    assign vencido  = (ciclos == LIMITE);

`ifdef BOOTH_CHECK_EN
    logic [2*N-1:0] esperado;

    // Reference product of the latched operands, sign-extended to 2N bits
    assign esperado = {{N{mult_q[N-1]}}, mult_q} * {{N{mult_m[N-1]}}, mult_m};
    assign mismatch_calc = (esperado != mult_resultado);
`else
    assign mismatch_calc = 1'b0;
`endif

    // Sequencer FSM: accept operands, pulse start, wait for fin or watchdog, return result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            mult_q       <= '0;
            mult_m       <= '0;
            mult_start   <= 1'b0;
            out_valid    <= 1'b0;
            out_producto <= '0;
            out_error    <= 1'b0;
            out_ciclos   <= '0;
            out_mismatch <= 1'b0;
            ciclos       <= '0;
            fin_bajo     <= 1'b0;
        end else begin
            mult_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mult_q     <= in_q;
                        mult_m     <= in_m;
                        ciclos     <= '0;
                        fin_bajo   <= 1'b0;
                        in_ready   <= 1'b0;
                        mult_start <= 1'b1;
                        state      <= ARRANQUE;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ARRANQUE: begin
                    ciclos <= CW'(1);
                    state  <= ESPERA;
                end
                ESPERA: begin
                    ciclos <= ciclos + CW'(1);
                    if (!mult_fin) begin
                        fin_bajo <= 1'b1;
                    end
                    if (completo) begin
                        out_producto <= mult_resultado;
                        out_ciclos   <= ciclos;
                        out_error    <= 1'b0;
                        out_mismatch <= mismatch_calc;
                        out_valid    <= 1'b1;
                        state        <= SALIDA;
                    end else if (vencido) begin
                        out_producto <= '0;
                        out_ciclos   <= LIMITE;
                        out_error    <= 1'b1;
                        out_mismatch <= 1'b0;
                        out_valid    <= 1'b1;
                        state        <= SALIDA;
                    end
                end
                SALIDA: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_secuenciador.sv
// Directed bench for booth_secuenciador with a behavioural Booth multiplier stand-in.
// Expected mismatch flag depends on BOOTH_CHECK_EN.
module tb_booth_secuenciador;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_q = '0;
    logic [3:0] in_m = '0;
    logic [3:0] mult_q;
    logic [3:0] mult_m;
    logic       mult_start;
    logic       mult_fin = 1'b1;
    logic [7:0] mult_resultado = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_producto;
    logic       out_error;
    logic [7:0] out_ciclos;
    logic       out_mismatch;

    int vectors = 0;
    int miscompares = 0;
    int nstart = 0;

    logic [7:0] model_res = '0;
    logic       fault = 1'b0;
    logic       stuck = 1'b0;
    logic       late = 1'b0;
    logic       drop_pend = 1'b0;
    int         cnt = 0;

`ifdef BOOTH_CHECK_EN
    localparam logic EXP_MIS = 1'b1;
`else
    localparam logic EXP_MIS = 1'b0;
`endif

    booth_secuenciador dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_q(in_q),
        .in_m(in_m),
        .mult_q(mult_q),
        .mult_m(mult_m),
        .mult_start(mult_start),
        .mult_fin(mult_fin),
        .mult_resultado(mult_resultado),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_producto(out_producto),
        .out_error(out_error),
        .out_ciclos(out_ciclos),
        .out_mismatch(out_mismatch)
    );

    always #5 clk = ~clk;

    // Booth stand-in: fin drops after start, rises 4 edges later with the product
    always @(posedge clk) begin
        if (mult_start) begin
            cnt <= 4;
            if (late) drop_pend <= 1'b1;
            else mult_fin <= 1'b0;
        end else begin
            if (drop_pend) begin
                mult_fin  <= 1'b0;
                drop_pend <= 1'b0;
            end
            if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1 && !stuck) begin
                    mult_fin       <= 1'b1;
                    mult_resultado <= model_res + {7'd0, fault};
                end
            end
        end
    end

    // Count start pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (mult_start) nstart <= nstart + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input string tag, input logic [3:0] q, input logic [3:0] m);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({"rdy_", tag}, 32'(in_ready), 1);
        in_q = q;
        in_m = m;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({"valid_", tag}, 32'(out_valid), 1);
    endtask

    task automatic run_op(input string tag, input logic [3:0] q, input logic [3:0] m,
                          input logic [7:0] res, input logic [7:0] exp_p,
                          input logic exp_e, input logic [7:0] exp_c, input logic exp_mis);
        int s0;
        model_res = res;
        s0 = nstart;
        send(tag, q, m);
        wait_out(tag);
        check({"prod_", tag}, 32'(out_producto), 32'(exp_p));
        check({"err_", tag}, 32'(out_error), 32'(exp_e));
        check({"cic_", tag}, 32'(out_ciclos), 32'(exp_c));
        check({"mis_", tag}, 32'(out_mismatch), 32'(exp_mis));
        check({"starts_", tag}, 32'(nstart - s0), 1);
        check({"q_", tag}, 32'(mult_q), 32'(q));
        if (!out_ready) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end else begin
            @(negedge clk);
        end
        check({"drop_", tag}, 32'(out_valid), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_start", 32'(mult_start), 0);
        check("rst_prod", 32'(out_producto), 0);
        check("rst_ciclos", 32'(out_ciclos), 0);
        reset = 1'b1;

        // Basic signed product: -7 * 5
        run_op("t1", 4'b1001, 4'b0101, 8'hDD, 8'hDD, 1'b0, 8'd5, 1'b0);

        // Back-to-back with consumer always ready
        out_ready = 1'b1;
        run_op("t2a", 4'b0111, 4'b0111, 8'h31, 8'h31, 1'b0, 8'd5, 1'b0);
        run_op("t2b", 4'b1000, 4'b1000, 8'h40, 8'h40, 1'b0, 8'd5, 1'b0);
        out_ready = 1'b0;

        // fin still high from the previous op during the first wait cycle
        late = 1'b1;
        run_op("stale", 4'b0100, 4'b0100, 8'h10, 8'h10, 1'b0, 8'd5, 1'b0);
        late = 1'b0;

        // Backpressure: result held, pending operands not accepted
        model_res = 8'hFA;
        send("t3", 4'b0011, 4'b1110);
        wait_out("t3");
        in_q = 4'b0010;
        in_m = 4'b0011;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(out_valid), 1);
            check("t3_hold_prod", 32'(out_producto), 32'hFA);
            check("t3_hold_ready", 32'(in_ready), 0);
            check("t3_hold_q", 32'(mult_q), 32'b0011);
        end
        model_res = 8'h06;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_hs", 32'(out_valid), 0);
        send("t3b", 4'b0010, 4'b0011);
        wait_out("t3b");
        check("t3b_prod", 32'(out_producto), 32'h06);
        check("t3b_q", 32'(mult_q), 32'b0010);
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset while waiting on the multiplier
        model_res = 8'h19;
        send("t5", 4'b0101, 4'b0101);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t5_valid", 32'(out_valid), 0);
        check("t5_in_ready", 32'(in_ready), 0);
        check("t5_start", 32'(mult_start), 0);
        check("t5_q", 32'(mult_q), 0);
        check("t5_prod", 32'(out_producto), 0);
        check("t5_ciclos", 32'(out_ciclos), 0);
        @(negedge clk);
        reset = 1'b1;
        run_op("t5b", 4'b1111, 4'b0001, 8'hFF, 8'hFF, 1'b0, 8'd5, 1'b0);

        // Faulty multiplier returns product + 1
        fault = 1'b1;
        run_op("t6", 4'b0110, 4'b1101, 8'hEE, 8'hEF, 1'b0, 8'd5, EXP_MIS);
        fault = 1'b0;

        // fin stuck low: watchdog abort
        stuck = 1'b1;
        run_op("t4", 4'b0001, 4'b0001, 8'h01, 8'h00, 1'b1, 8'd64, 1'b0);
        stuck = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
